// File: rtl/autoconfig_pkg.sv
// autoconfig_pkg: register offsets, region limits, walk states and size decode shared by the AutoConfig host
package autoconfig_pkg;

   localparam logic [15:0] OFF_TYPE    = 16'h0000;
   localparam logic [15:0] OFF_SIZE    = 16'h0002;
   localparam logic [15:0] OFF_FLAGS   = 16'h0008;
   localparam logic [15:0] OFF_MFG     = 16'h0010;
   localparam logic [15:0] OFF_BASE_HI = 16'h0048;
   localparam logic [15:0] OFF_BASE_LO = 16'h004A;
   localparam logic [15:0] OFF_SHUT    = 16'h004C;

   localparam logic [7:0] AC_SPACE  = 8'hE8;
   localparam logic [8:0] MEM_START = 9'h020;
   localparam logic [8:0] MEM_END   = 9'h0A0;
   localparam logic [8:0] IO_START  = 9'h0E9;
   localparam logic [8:0] IO_END    = 9'h0F0;

   typedef enum logic [3:0] {
      S_IDLE, S_RD_TYPE, S_RD_SIZE, S_RD_FLAGS,
      S_RD_MFG0, S_RD_MFG1, S_RD_MFG2, S_RD_MFG3,
      S_ALLOC, S_WR_LO, S_WR_HI, S_WR_SHUT, S_NEXT, S_DONE
   } state_t;

   // Board size in 64 KB units; code 0 is the largest (8 MB)
   function automatic logic [8:0] size_decode(input logic [2:0] code);
      return (code == 3'd0) ? 9'd128 : 9'd1 << (code - 3'd1);
   endfunction

endpackage

// File: rtl/autoconfig_host_ac_alloc.sv
// ac_alloc: aligns a pointer up to the board size and tests whether the board fits below the region end
module ac_alloc (
   input  logic [8:0] i_ptr,
   input  logic [8:0] i_size,
   input  logic [8:0] i_end,
   output logic [7:0] o_base,
   output logic       o_fit,
   output logic [8:0] o_next
);

   logic [9:0] w_base;
   logic [9:0] w_top;

   // Natural alignment, with one spare bit so an overshoot past $FF is still seen as no-fit
   always_comb begin
      w_base = ({1'b0, i_ptr} + {1'b0, i_size} - 10'd1) & ~{1'b0, i_size - 9'd1};
      w_top  = w_base + {1'b0, i_size};
      o_fit  = w_top <= {1'b0, i_end};
      o_base = w_base[7:0];
      o_next = w_top[8:0];
   end

endmodule

// File: rtl/autoconfig_host.sv
// autoconfig_host: Zorro II AutoConfig chain walker; AUTOCONFIG_HOST_LOG_EN adds a per-board base/size/manufacturer table
module autoconfig_host
   import autoconfig_pkg::*;
#(
   parameter int MAX_BOARDS     = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        start,
   output logic        bus_req,
   output logic        bus_rw,
   output logic [22:0] bus_addr,
   output logic [3:0]  bus_wdata,
   input  logic [3:0]  bus_rdata,
   input  logic        bus_ack,
`ifdef AUTOCONFIG_HOST_LOG_EN
   input  logic [2:0]  log_idx,
   output logic [7:0]  log_base,
   output logic [7:0]  log_size,
   output logic [15:0] log_mfg,
`endif
   output logic        busy,
   output logic        done,
   output logic [3:0]  board_count,
   output logic        overflow
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   state_t        r_state;
   logic          r_bus_req;
   logic          r_bus_rw;
   logic [22:0]   r_bus_addr;
   logic [3:0]    r_bus_wdata;
   logic          r_busy;
   logic          r_done;
   logic [3:0]    r_board_count;
   logic          r_overflow;
   logic [TW-1:0] r_tmo;
   logic [2:0]    r_nib0;
   logic          r_mem;
   logic [2:0]    r_code;
   logic          r_no_shut;
   logic [7:0]    r_base;
   logic [8:0]    r_mem_ptr;
   logic [8:0]    r_io_ptr;
`ifdef AUTOCONFIG_HOST_LOG_EN
   logic [15:0]   r_mfg;
   logic [7:0]    r_size;
   logic [7:0]    r_log_base [8];
   logic [7:0]    r_log_size [8];
   logic [15:0]   r_log_mfg  [8];
`endif

   logic [15:0]   w_off;
   logic          w_rd;
   logic [3:0]    w_wdata;
   logic [22:0]   w_addr;
   logic [8:0]    w_size;
   logic [7:0]    w_base;
   logic          w_fit;
   logic [8:0]    w_next;

   // Bus-cycle parameters implied by the state that is about to issue a request
   always_comb begin
      w_off   = r_state == S_RD_SIZE  ? OFF_SIZE :
                r_state == S_RD_FLAGS ? OFF_FLAGS :
                r_state == S_RD_MFG0  ? OFF_MFG :
                r_state == S_RD_MFG1  ? OFF_MFG + 16'd2 :
                r_state == S_RD_MFG2  ? OFF_MFG + 16'd4 :
                r_state == S_RD_MFG3  ? OFF_MFG + 16'd6 :
                r_state == S_WR_LO    ? OFF_BASE_LO :
                r_state == S_WR_HI    ? OFF_BASE_HI :
                r_state == S_WR_SHUT  ? OFF_SHUT : OFF_TYPE;
      w_rd    = !(r_state inside {S_WR_LO, S_WR_HI, S_WR_SHUT});
      w_wdata = r_state == S_WR_LO ? r_base[3:0] : r_state == S_WR_HI ? r_base[7:4] : 4'h0;
      w_addr  = {AC_SPACE, 15'(w_off >> 1)};
      w_size  = size_decode(r_code);
   end

   ac_alloc u_alloc (
      .i_ptr  (r_mem ? r_mem_ptr : r_io_ptr),
      .i_size (w_size),
      .i_end  (r_mem ? MEM_END : IO_END),
      .o_base (w_base),
      .o_fit  (w_fit),
      .o_next (w_next)
   );

   // Chain-walk sequencer: issues one nibble cycle per bus state, decodes the board and places it
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state       <= S_IDLE;
         r_bus_req     <= 1'b0;
         r_bus_rw      <= 1'b1;
         r_bus_addr    <= '0;
         r_bus_wdata   <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_board_count <= '0;
         r_overflow    <= 1'b0;
         r_tmo         <= '0;
         r_nib0        <= '0;
         r_mem         <= 1'b0;
         r_code        <= '0;
         r_no_shut     <= 1'b0;
         r_base        <= '0;
         r_mem_ptr     <= MEM_START;
         r_io_ptr      <= IO_START;
`ifdef AUTOCONFIG_HOST_LOG_EN
         r_mfg         <= '0;
         r_size        <= '0;
         for (int i = 0; i < 8; i++) begin
            r_log_base[i] <= '0;
            r_log_size[i] <= '0;
            r_log_mfg[i]  <= '0;
         end
`endif
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state       <= S_RD_TYPE;
                  r_busy        <= 1'b1;
                  r_done        <= 1'b0;
                  r_board_count <= '0;
                  r_overflow    <= 1'b0;
                  r_mem_ptr     <= MEM_START;
                  r_io_ptr      <= IO_START;
                  r_bus_req     <= 1'b1;
                  r_bus_rw      <= w_rd;
                  r_bus_addr    <= w_addr;
                  r_bus_wdata   <= w_wdata;
                  r_tmo         <= '0;
`ifdef AUTOCONFIG_HOST_LOG_EN
                  for (int i = 0; i < 8; i++) begin
                     r_log_base[i] <= '0;
                     r_log_size[i] <= '0;
                     r_log_mfg[i]  <= '0;
                  end
`endif
               end
            end
            S_ALLOC: begin
               if (w_fit) begin
                  r_base  <= w_base;
                  r_state <= S_WR_LO;
                  if (r_mem) r_mem_ptr <= w_next;
                  else r_io_ptr <= w_next;
`ifdef AUTOCONFIG_HOST_LOG_EN
                  r_size  <= w_size[7:0];
`endif
               end else begin
                  r_overflow <= 1'b1;
                  if (r_no_shut) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else r_state <= S_WR_SHUT;
               end
            end
            S_NEXT: begin
               if (r_board_count == 4'(MAX_BOARDS)) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else r_state <= S_RD_TYPE;
            end
            default: begin
               if (!r_bus_req) begin
                  r_bus_req   <= 1'b1;
                  r_bus_rw    <= w_rd;
                  r_bus_addr  <= w_addr;
                  r_bus_wdata <= w_wdata;
                  r_tmo       <= '0;
               end else if (bus_ack) begin
                  r_bus_req <= 1'b0;
                  case (r_state)
                     S_RD_TYPE: begin
                        r_nib0  <= bus_rdata[3:1];
                        r_state <= S_RD_SIZE;
                     end
                     S_RD_SIZE: begin
                        r_mem  <= r_nib0[0];
                        r_code <= bus_rdata[2:0];
                        if (r_nib0[2:1] != 2'b11) begin
                           r_state <= S_DONE;
                           r_busy  <= 1'b0;
                           r_done  <= 1'b1;
                        end else r_state <= S_RD_FLAGS;
                     end
                     S_RD_FLAGS: begin
                        r_no_shut <= ~bus_rdata[2];
`ifdef AUTOCONFIG_HOST_LOG_EN
                        r_state   <= S_RD_MFG0;
`else
                        r_state   <= S_ALLOC;
`endif
                     end
`ifdef AUTOCONFIG_HOST_LOG_EN
                     S_RD_MFG0: begin
                        r_mfg   <= {r_mfg[11:0], ~bus_rdata};
                        r_state <= S_RD_MFG1;
                     end
                     S_RD_MFG1: begin
                        r_mfg   <= {r_mfg[11:0], ~bus_rdata};
                        r_state <= S_RD_MFG2;
                     end
                     S_RD_MFG2: begin
                        r_mfg   <= {r_mfg[11:0], ~bus_rdata};
                        r_state <= S_RD_MFG3;
                     end
                     S_RD_MFG3: begin
                        r_mfg   <= {r_mfg[11:0], ~bus_rdata};
                        r_state <= S_ALLOC;
                     end
`endif
                     S_WR_LO: r_state <= S_WR_HI;
                     S_WR_HI: begin
                        r_board_count <= r_board_count + 4'd1;
                        r_state       <= S_NEXT;
`ifdef AUTOCONFIG_HOST_LOG_EN
                        if (!r_board_count[3]) begin
                           r_log_base[r_board_count[2:0]] <= r_base;
                           r_log_size[r_board_count[2:0]] <= r_size;
                           r_log_mfg[r_board_count[2:0]]  <= r_mfg;
                        end
`endif
                     end
                     S_WR_SHUT: r_state <= S_NEXT;
                     default: r_state <= S_DONE;
                  endcase
               end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                  r_bus_req <= 1'b0;
                  r_state   <= S_DONE;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
               end else r_tmo <= r_tmo + 1'b1;
            end
         endcase
      end
   end

   assign bus_req     = r_bus_req;
   assign bus_rw      = r_bus_rw;
   assign bus_addr    = r_bus_addr;
   assign bus_wdata   = r_bus_wdata;
   assign busy        = r_busy;
   assign done        = r_done;
   assign board_count = r_board_count;
   assign overflow    = r_overflow;
`ifdef AUTOCONFIG_HOST_LOG_EN
   assign log_base    = r_log_base[log_idx];
   assign log_size    = r_log_size[log_idx];
   assign log_mfg     = r_log_mfg[log_idx];
`endif

endmodule

// File: tb/tb_autoconfig_host.sv
// tb_autoconfig_host: directed chain-walk scenarios against a modelled responder chain
module tb_autoconfig_host;

   localparam int TMO = 255;
   localparam logic [22:0] A_00   = 23'h740000;
   localparam logic [22:0] A_02   = 23'h740001;
   localparam logic [22:0] A_08   = 23'h740004;
   localparam logic [22:0] A_HI   = 23'h740024;
   localparam logic [22:0] A_LO   = 23'h740025;
   localparam logic [22:0] A_SHUT = 23'h740026;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        start = 1'b0;
   logic        bus_req, bus_rw, busy, done, overflow;
   logic [22:0] bus_addr;
   logic [3:0]  bus_wdata, board_count;
   logic [3:0]  bus_rdata = 4'h0;
   logic        bus_ack = 1'b0;

   logic [3:0]  nib0 [8];
   logic [3:0]  nib2 [8];
   logic [3:0]  nib8 [8];
   int          n_brd = 0;
   int          cur = 0;
   logic        stall_hi = 1'b0;
   logic [22:0] wa [$];
   logic [3:0]  wd [$];
   logic [22:0] ea [$];
   logic [3:0]  ed [$];
   int          n_chk = 0;
   int          n_err = 0;
   int          req_cyc = 0;

   always #5 CLK = ~CLK;

   autoconfig_host dut (
      .CLK(CLK), .RST(RST), .start(start),
      .bus_req(bus_req), .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack),
      .busy(busy), .done(done), .board_count(board_count), .overflow(overflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Responder chain: the current unconfigured board answers; writing $48 or $4C passes on to the next
   initial begin
      forever begin
         @(negedge CLK);
         if (bus_ack) bus_ack = 1'b0;
         else if (bus_req && cur < n_brd && !(stall_hi && bus_addr == A_HI)) begin
            bus_ack = 1'b1;
            if (!bus_rw) begin
               wa.push_back(bus_addr);
               wd.push_back(bus_wdata);
               if (bus_addr == A_HI || bus_addr == A_SHUT) cur++;
            end else
               bus_rdata = bus_addr == A_00 ? nib0[cur] : bus_addr == A_02 ? nib2[cur] :
                           bus_addr == A_08 ? nib8[cur] : 4'h0;
         end
      end
   end

   task automatic board(input int i, input logic [3:0] n0, input logic [3:0] n2, input logic [3:0] n8);
      nib0[i] = n0;
      nib2[i] = n2;
      nib8[i] = n8;
   endtask

   task automatic expect_wr(input logic [22:0] a, input logic [3:0] d);
      ea.push_back(a);
      ed.push_back(d);
   endtask

   task automatic walk(input string tag, input int boards);
      n_brd = boards;
      cur = 0;
      @(negedge CLK);
      start = 1'b1;
      req_cyc = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge CLK);
         start = 1'b0;
         if (bus_req) req_cyc++;
         if (done) break;
      end
      check({tag, "_done"}, done, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_req"}, bus_req, 0);
   endtask

   task automatic check_wr(input string tag);
      check({tag, "_nwr"}, wa.size(), ea.size());
      for (int i = 0; i < wa.size() && i < ea.size(); i++) begin
         check($sformatf("%s_wa%0d", tag, i), wa[i], ea[i]);
         check($sformatf("%s_wd%0d", tag, i), wd[i], ed[i]);
      end
      wa.delete();
      wd.delete();
      ea.delete();
      ed.delete();
   endtask

   initial begin
      bit found;
      repeat (3) @(negedge CLK);
      check("rst_req", bus_req, 0);
      check("rst_rw", bus_rw, 1);
      check("rst_addr", bus_addr, 0);
      check("rst_wdata", bus_wdata, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cnt", board_count, 0);
      check("rst_ovf", overflow, 0);
      RST = 1'b0;

      board(0, 4'hE, 4'h6, 4'h7);
      expect_wr(A_LO, 4'h0);
      expect_wr(A_HI, 4'h2);
      walk("single", 1);
      check("single_cnt", board_count, 1);
      check("single_ovf", overflow, 0);
      check("single_cyc", req_cyc, 5 + TMO);
      check_wr("single");

      for (int i = 0; i < 3; i++) board(i, 4'hE, 4'h6, 4'h7);
      expect_wr(A_LO, 4'h0); expect_wr(A_HI, 4'h2);
      expect_wr(A_LO, 4'h0); expect_wr(A_HI, 4'h4);
      expect_wr(A_LO, 4'h0); expect_wr(A_HI, 4'h6);
      walk("three", 3);
      check("three_cnt", board_count, 3);
      check_wr("three");

      board(0, 4'hE, 4'h7, 4'h7);
      board(1, 4'hE, 4'h0, 4'h7);
      expect_wr(A_LO, 4'h0); expect_wr(A_HI, 4'h4); expect_wr(A_SHUT, 4'h0);
      walk("ovf", 2);
      check("ovf_cnt", board_count, 1);
      check("ovf_flag", overflow, 1);
      check_wr("ovf");

      board(1, 4'hE, 4'h0, 4'hB);
      expect_wr(A_LO, 4'h0); expect_wr(A_HI, 4'h4);
      walk("noshut", 2);
      check("noshut_cnt", board_count, 1);
      check("noshut_flag", overflow, 1);
      check("noshut_cyc", req_cyc, 8);
      check_wr("noshut");

      board(0, 4'hC, 4'h1, 4'h7);
      expect_wr(A_LO, 4'h9); expect_wr(A_HI, 4'hE);
      walk("io", 1);
      check("io_cnt", board_count, 1);
      check("io_ovf", overflow, 0);
      check_wr("io");

      board(0, 4'h0, 4'h6, 4'h7);
      walk("inval", 1);
      check("inval_cnt", board_count, 0);
      check("inval_cyc", req_cyc, 2);
      check_wr("inval");

      walk("empty", 0);
      check("empty_cnt", board_count, 0);
      check("empty_cyc", req_cyc, TMO);
      check_wr("empty");

      for (int i = 0; i < 8; i++) begin
         board(i, 4'hE, 4'h1, 4'h7);
         expect_wr(A_LO, 4'(i));
         expect_wr(A_HI, 4'h2);
      end
      walk("max", 8);
      check("max_cnt", board_count, 8);
      check("max_cyc", req_cyc, 40);
      check_wr("max");

      board(0, 4'hE, 4'h6, 4'h7);
      n_brd = 1;
      cur = 0;
      stall_hi = 1'b1;
      @(negedge CLK);
      start = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge CLK);
         start = 1'b0;
         found = bus_req && bus_addr == A_HI;
      end
      check("rst_wait_hi", found, 1);
      #2 RST = 1'b1;
      #1;
      check("mid_req", bus_req, 0);
      check("mid_rw", bus_rw, 1);
      check("mid_addr", bus_addr, 0);
      check("mid_busy", busy, 0);
      check("mid_done", done, 0);
      check("mid_cnt", board_count, 0);
      @(negedge CLK);
      RST = 1'b0;
      stall_hi = 1'b0;
      wa.delete();
      wd.delete();
      expect_wr(A_LO, 4'h0); expect_wr(A_HI, 4'h2);
      walk("rewalk", 1);
      check("rewalk_cnt", board_count, 1);
      check_wr("rewalk");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
